// File: rtl/chunk_io_buffer_if.sv
// Bundle of audio-side and processor-side signals for the chunk I/O buffer.
// The master drives strobes, samples and processor accesses; the slave is the buffer.
interface chunk_io_buffer_if #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
);
  logic                        sample_strobe;
  logic [SAMPLE_SIZE-1:0]      in_sample;
  logic [SAMPLE_SIZE-1:0]      out_sample;
  logic                        out_valid;
  logic                        chunk_pulse;
  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr;
  logic [SAMPLE_SIZE-1:0]      input_buff_sample;
  logic [IO_BUFF_PTR_BITS-1:0] output_buff_ptr;
  logic [SAMPLE_SIZE-1:0]      output_buff_sample;
  logic                        output_buff_write_pulse;
  logic                        underrun_flag;
  logic [7:0]                  underrun_count;

  modport master (
    output sample_strobe, in_sample, input_buff_ptr, output_buff_ptr,
           output_buff_sample, output_buff_write_pulse,
    input  out_sample, out_valid, chunk_pulse, input_buff_sample,
           underrun_flag, underrun_count
  );

  modport slave (
    input  sample_strobe, in_sample, input_buff_ptr, output_buff_ptr,
           output_buff_sample, output_buff_write_pulse,
    output out_sample, out_valid, chunk_pulse, input_buff_sample,
           underrun_flag, underrun_count
  );
endinterface

// File: rtl/chunk_io_buffer.sv
// Ping-pong sample buffer: the audio side works bank bank_sel while the chunk
// processor reads/writes bank ~bank_sel; banks swap after every full chunk.
module chunk_io_buffer #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input logic               clk,
  input logic               rst,
  chunk_io_buffer_if.slave  bus
);

  localparam int CNT_W = IO_BUFF_PTR_BITS + 1;
  localparam logic [CNT_W-1:0]            FULL_CNT = CNT_W'(IO_BUFF_SIZE);
  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_IDX = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

  state_t state, state_nxt;

  logic [SAMPLE_SIZE-1:0] in_mem  [0:1][0:IO_BUFF_SIZE-1];
  logic [SAMPLE_SIZE-1:0] out_mem [0:1][0:IO_BUFF_SIZE-1];

  logic                        bank_sel;
  logic [IO_BUFF_PTR_BITS-1:0] cap_idx;
  logic [CNT_W-1:0]            wr_cnt;
  logic [CNT_W-1:0]            wr_cnt_inc;
  logic                        strobe;
  logic                        wr_en;
  logic                        swap;
  logic                        short_chunk;

  // A write landing in the swap cycle is folded into wr_cnt_inc so it counts
  // toward the chunk that is finishing.
  always_comb begin
    strobe      = bus.sample_strobe & ~rst;
    wr_en       = bus.output_buff_write_pulse & ~rst;
    swap        = strobe && (cap_idx == LAST_IDX);
    wr_cnt_inc  = (wr_en && (wr_cnt != FULL_CNT)) ? wr_cnt + 1'b1 : wr_cnt;
    short_chunk = (state != PRIME0) && (wr_cnt_inc != FULL_CNT);
  end

  always_comb begin
    state_nxt = state;
    if (swap) begin
      case (state)
        PRIME0:  state_nxt = PRIME1;
        PRIME1:  state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= PRIME0;
    else     state <= state_nxt;
  end

  // Sample storage is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (strobe) in_mem[bank_sel][cap_idx] <= bus.in_sample;
    if (wr_en)  out_mem[~bank_sel][bus.output_buff_ptr] <= bus.output_buff_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel              <= 1'b0;
      cap_idx               <= '0;
      wr_cnt                <= '0;
      bus.out_sample        <= '0;
      bus.out_valid         <= 1'b0;
      bus.chunk_pulse       <= 1'b0;
      bus.input_buff_sample <= '0;
      bus.underrun_flag     <= 1'b0;
      bus.underrun_count    <= 8'd0;
    end else begin
      bus.out_valid         <= strobe;
      bus.chunk_pulse       <= swap;
      bus.input_buff_sample <= in_mem[~bank_sel][bus.input_buff_ptr];
      if (strobe) begin
        // PRIME1 bank holds nothing processed yet, so silence is played.
        bus.out_sample <= (state == RUN) ? out_mem[bank_sel][cap_idx] : '0;
        cap_idx        <= cap_idx + 1'b1;
      end
      if (swap) begin
        bank_sel <= ~bank_sel;
        wr_cnt   <= '0;
        if (short_chunk) begin
          bus.underrun_flag <= 1'b1;
          if (bus.underrun_count != 8'hFF) bus.underrun_count <= bus.underrun_count + 8'd1;
        end
      end else begin
        wr_cnt <= wr_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_chunk_io_buffer.sv
// Randomized and directed bench for chunk_io_buffer with a chunk-level reference
// model (strobe count since reset -> period, index and bank parity).
module tb_chunk_io_buffer;

  localparam int SS = 24;
  localparam int N  = 8;
  localparam int PB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunk_io_buffer_if #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N)) bus ();

  chunk_io_buffer #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  int            k;
  int            wr;
  logic [SS-1:0] m_in  [2][N];
  logic [SS-1:0] m_out [2][N];
  bit            k_in  [2][N];
  bit            k_out [2][N];
  logic [SS-1:0] e_out, e_ibs;
  bit            e_out_ok, e_ibs_ok, e_vld, e_cp, e_flag;
  int            e_cnt;

  logic [SS-1:0] played [$];
  int            pos [$];
  int            nz;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Applies the inputs present just before the coming edge to the model.
  task automatic model_step();
    int p, i, ab, pbk;
    if (rst) begin
      k = 0; wr = 0;
      e_out = '0; e_out_ok = 1; e_ibs = '0; e_ibs_ok = 1;
      e_vld = 0; e_cp = 0; e_flag = 0; e_cnt = 0;
    end else begin
      p   = k / N;
      i   = k % N;
      ab  = p % 2;
      pbk = 1 - ab;
      e_ibs    = m_in[pbk][bus.input_buff_ptr];
      e_ibs_ok = k_in[pbk][bus.input_buff_ptr];
      if (bus.output_buff_write_pulse) begin
        m_out[pbk][bus.output_buff_ptr] = bus.output_buff_sample;
        k_out[pbk][bus.output_buff_ptr] = 1;
        if (wr < N) wr++;
      end
      e_vld = bus.sample_strobe;
      e_cp  = 0;
      if (bus.sample_strobe) begin
        m_in[ab][i] = bus.in_sample;
        k_in[ab][i] = 1;
        if (p >= 2) begin
          e_out    = m_out[ab][i];
          e_out_ok = k_out[ab][i];
        end else begin
          e_out    = '0;
          e_out_ok = 1;
        end
        if (i == N - 1) begin
          e_cp = 1;
          if (p >= 1 && wr != N) begin
            e_flag = 1;
            if (e_cnt < 255) e_cnt++;
          end
          wr = 0;
        end
        k++;
      end
    end
  endtask

  task automatic compare_all();
    if (e_out_ok) chk("out_sample", 32'(bus.out_sample), 32'(e_out));
    chk("out_valid", 32'(bus.out_valid), 32'(e_vld));
    chk("chunk_pulse", 32'(bus.chunk_pulse), 32'(e_cp));
    if (e_ibs_ok) chk("input_buff_sample", 32'(bus.input_buff_sample), 32'(e_ibs));
    chk("underrun_flag", 32'(bus.underrun_flag), 32'(e_flag));
    chk("underrun_count", 32'(bus.underrun_count), 32'(e_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    bus.sample_strobe           = 1'b0;
    bus.output_buff_write_pulse = 1'b0;
  endtask

  // One chunk of loopback: read ptr i, then strobe while writing back what was read.
  task automatic run_chunk(input int base, input int nwr, input bit special);
    for (int i = 0; i < N; i++) begin
      bus.input_buff_ptr = PB'(i);
      tick();
      bus.sample_strobe = 1'b1;
      bus.in_sample     = SS'(base + i);
      if (i < nwr) begin
        bus.output_buff_write_pulse = 1'b1;
        bus.output_buff_ptr         = PB'(i);
        bus.output_buff_sample      = (special && i == N - 1) ? 24'hABCDEF : bus.input_buff_sample;
      end
      tick();
      played.push_back(bus.out_sample);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.sample_strobe = 1'b1;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    int wp, gap;
    rst                         = 1'b1;
    bus.sample_strobe           = 1'b0;
    bus.in_sample               = '0;
    bus.input_buff_ptr          = '0;
    bus.output_buff_ptr         = '0;
    bus.output_buff_sample      = '0;
    bus.output_buff_write_pulse = 1'b0;

    do_reset(2);
    chk("rst_out_sample", 32'(bus.out_sample), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_chunk_pulse", 32'(bus.chunk_pulse), 32'd0);
    chk("rst_input_buff_sample", 32'(bus.input_buff_sample), 32'd0);
    chk("rst_underrun_count", 32'(bus.underrun_count), 32'd0);

    // Capture, swap and processor read-back.
    played.delete();
    run_chunk(1, 8, 0);
    chk("s1_chunk_pulse", 32'(bus.chunk_pulse), 32'd1);
    for (int j = 0; j < N; j++) begin
      bus.input_buff_ptr = PB'(j);
      tick();
      chk("s1_read", 32'(bus.input_buff_sample), 32'(j + 1));
    end

    // Loopback: two chunks of silence, then the first chunk plays.
    run_chunk(9, 8, 0);
    run_chunk(17, 8, 0);
    for (int j = 0; j < 3 * N; j++)
      chk("s2_played", 32'(played[j]), (j < 2 * N) ? 32'd0 : 32'(j - 2 * N + 1));
    chk("s2_underrun_count", 32'(bus.underrun_count), 32'd0);

    // Write coinciding with the swap strobe.
    run_chunk(25, 8, 1);
    run_chunk(33, 8, 0);
    chk("s4_swap_write_played", 32'(played[played.size() - 1]), 32'hABCDEF);
    chk("s4_no_underrun", 32'(bus.underrun_flag), 32'd0);

    // Reset three strobes into a RUN chunk.
    for (int j = 0; j < 3; j++) begin
      bus.sample_strobe = 1'b1;
      bus.in_sample     = SS'(200 + j);
      tick();
    end
    do_reset(1);
    chk("s5_out_sample", 32'(bus.out_sample), 32'd0);
    chk("s5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s5_input_buff_sample", 32'(bus.input_buff_sample), 32'd0);

    // Short second chunk after reset.
    played.delete();
    run_chunk(100, 8, 0);
    chk("s5_chunk_pulse", 32'(bus.chunk_pulse), 32'd1);
    run_chunk(108, 5, 0);
    chk("s3_flag", 32'(bus.underrun_flag), 32'd1);
    chk("s3_count", 32'(bus.underrun_count), 32'd1);
    run_chunk(116, 8, 0);
    chk("s3_count_hold", 32'(bus.underrun_count), 32'd1);
    nz = 0;
    for (int j = 0; j < 2 * N; j++) if (played[j] != '0) nz++;
    chk("s5_prime_silence", 32'(nz), 32'd0);

    // Back-to-back strobes.
    pos.delete();
    for (int j = 0; j < 2 * N; j++) begin
      bus.sample_strobe = 1'b1;
      bus.in_sample     = SS'($urandom);
      tick();
      chk("s6_out_valid", 32'(bus.out_valid), 32'd1);
      if (bus.chunk_pulse) pos.push_back(j);
    end
    chk("s6_pulse_count", 32'(pos.size()), 32'd2);
    if (pos.size() == 2) begin
      chk("s6_first_pulse", 32'(pos[0]), 32'd7);
      chk("s6_pulse_gap", 32'(pos[1] - pos[0]), 32'd8);
    end

    // Randomized traffic with gaps, repeated pointers and occasional short chunks.
    do_reset(1);
    for (int c = 0; c < 40; c++) begin
      wp = ($urandom_range(0, 3) == 0) ? 20 : 85;
      for (int s = 0; s < N; s++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= gap; g++) begin
          bus.input_buff_ptr = PB'($urandom_range(0, N - 1));
          if ($urandom_range(0, 99) < wp) begin
            bus.output_buff_write_pulse = 1'b1;
            bus.output_buff_ptr         = PB'($urandom_range(0, N - 1));
            bus.output_buff_sample      = SS'($urandom);
          end
          if (g == gap) begin
            bus.sample_strobe = 1'b1;
            bus.in_sample     = SS'($urandom);
          end
          tick();
        end
      end
    end

    // Starved processor until the underrun counter saturates.
    for (int c = 0; c < 260; c++) begin
      for (int s = 0; s < N; s++) begin
        bus.sample_strobe = 1'b1;
        bus.in_sample     = SS'($urandom);
        tick();
      end
    end
    chk("sat_count", 32'(bus.underrun_count), 32'd255);
    chk("sat_flag", 32'(bus.underrun_flag), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
